// File: rtl/text_pixel_renderer.sv
// Character-cell text renderer: maps a scan position to a cell fetch, a font-row fetch and
// one monochrome pixel, three cycles after the request.
module text_pixel_renderer #(
  parameter int unsigned HORIZONTAL_WIDTH = 1650,
  parameter int unsigned VERTICAL_WIDTH   = 750,
  parameter int unsigned COLUMNS          = 16,
  parameter int unsigned ROWS             = 19,
  parameter int unsigned CHAR_PIXELS_X    = 8,
  parameter int unsigned CHAR_PIXELS_Y    = 16,
  parameter int unsigned SCALE_X          = 1,
  parameter int unsigned SCALE_Y          = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [$clog2(HORIZONTAL_WIDTH)-1:0]  i_sx,
  input  logic [$clog2(VERTICAL_WIDTH)-1:0]    i_sy,
  input  logic [$clog2(HORIZONTAL_WIDTH)-1:0]  i_x,
  input  logic [$clog2(VERTICAL_WIDTH)-1:0]    i_y,
  input  logic                                 i_rd_en,
  output logic                                 o_cell_rd,
  output logic [$clog2(COLUMNS*ROWS)-1:0]      o_cell_addr,
  input  logic [7:0]                           i_cell_data,
  output logic                                 o_font_rd,
  output logic [$clog2(256*CHAR_PIXELS_Y)-1:0] o_font_addr,
  input  logic [CHAR_PIXELS_X-1:0]             i_font_row,
  output logic                                 o_rd_dv,
  output logic                                 o_data,
  output logic                                 o_in_window
);

  localparam int unsigned XW     = $clog2(HORIZONTAL_WIDTH);
  localparam int unsigned YW     = $clog2(VERTICAL_WIDTH);
  localparam int unsigned CAW    = $clog2(COLUMNS * ROWS);
  localparam int unsigned FAW    = $clog2(256 * CHAR_PIXELS_Y);
  localparam int unsigned GXW    = (CHAR_PIXELS_X > 1) ? $clog2(CHAR_PIXELS_X) : 1;
  localparam int unsigned GYW    = (CHAR_PIXELS_Y > 1) ? $clog2(CHAR_PIXELS_Y) : 1;
  localparam int unsigned CELL_W = CHAR_PIXELS_X * SCALE_X;
  localparam int unsigned CELL_H = CHAR_PIXELS_Y * SCALE_Y;
  localparam int unsigned WIN_W  = COLUMNS * CELL_W;
  localparam int unsigned WIN_H  = ROWS * CELL_H;

  // Stage 0: window test and cell/glyph coordinates
  logic [XW:0]    rel_x;
  logic [YW:0]    rel_y;
  logic           in_window;
  int unsigned    col;
  int unsigned    row;
  logic [GXW-1:0] glyph_x;
  logic [GYW-1:0] glyph_y;
  logic [CAW-1:0] cell_addr_d;

  always_comb begin
    // The extra MSB flags scan positions left of / above the window origin.
    rel_x       = {1'b0, i_sx} - {1'b0, i_x};
    rel_y       = {1'b0, i_sy} - {1'b0, i_y};
    in_window   = !rel_x[XW] && (32'(rel_x) < WIN_W) && !rel_y[YW] && (32'(rel_y) < WIN_H);
    col         = 32'(rel_x) / CELL_W;
    row         = 32'(rel_y) / CELL_H;
    glyph_x     = GXW'((32'(rel_x) / SCALE_X) % CHAR_PIXELS_X);
    glyph_y     = GYW'((32'(rel_y) / SCALE_Y) % CHAR_PIXELS_Y);
    cell_addr_d = CAW'(row * COLUMNS + col);
  end

  logic           s1_valid, s1_in_win;
  logic [GXW-1:0] s1_gx;
  logic [GYW-1:0] s1_gy;
  logic           s2_valid, s2_in_win;
  logic [GXW-1:0] s2_gx;

  logic           s1_hit;
  logic           s2_hit;
  logic [FAW-1:0] font_addr_d;
  logic [GXW-1:0] bit_idx;

  always_comb begin
    s1_hit      = i_rd_en && in_window;
    s2_hit      = s1_valid && s1_in_win;
    font_addr_d = FAW'(32'(i_cell_data) * CHAR_PIXELS_Y + 32'(s1_gy));
    // Font rows are stored MSB-first, so glyph column 0 is the top bit.
    bit_idx     = GXW'(CHAR_PIXELS_X - 1) - s2_gx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cell_rd   <= 1'b0;
      o_cell_addr <= '0;
      s1_valid    <= 1'b0;
      s1_in_win   <= 1'b0;
      s1_gx       <= '0;
      s1_gy       <= '0;
      o_font_rd   <= 1'b0;
      o_font_addr <= '0;
      s2_valid    <= 1'b0;
      s2_in_win   <= 1'b0;
      s2_gx       <= '0;
      o_rd_dv     <= 1'b0;
      o_data      <= 1'b0;
      o_in_window <= 1'b0;
    end else begin
      // Stage 1: cell buffer read
      o_cell_rd <= s1_hit;
      if (s1_hit) o_cell_addr <= cell_addr_d;
      s1_valid  <= i_rd_en;
      s1_in_win <= s1_hit;
      s1_gx     <= glyph_x;
      s1_gy     <= glyph_y;
      // Stage 2: font ROM read, addressed by the returned character code
      o_font_rd <= s2_hit;
      if (s2_hit) o_font_addr <= font_addr_d;
      s2_valid  <= s1_valid;
      s2_in_win <= s2_hit;
      s2_gx     <= s1_gx;
      // Stage 3: pixel select
      o_rd_dv     <= s2_valid;
      o_data      <= s2_valid && s2_in_win && i_font_row[bit_idx];
      o_in_window <= s2_valid && s2_in_win;
    end
  end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Directed bench for text_pixel_renderer: default geometry plus a 2x-scaled instance,
// backed by behavioural cell/font memories that answer from the registered addresses.
module tb_text_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] sx, x;
  logic [9:0]  sy, y;
  logic        rd_en;

  logic        cell_rd, font_rd, rd_dv, data, in_win;
  logic [8:0]  cell_addr;
  logic [11:0] font_addr;
  logic [7:0]  cell_data, font_row;

  logic        cell_rd2, font_rd2, rd_dv2, data2, in_win2;
  logic [8:0]  cell_addr2;
  logic [11:0] font_addr2;
  logic [7:0]  cell_data2, font_row2;

  logic [7:0]  cell_mem [512];
  logic [7:0]  font_mem [4096];

  // The DUT's registered address acts as the memory's address register.
  assign cell_data  = cell_mem[cell_addr];
  assign font_row   = font_mem[font_addr];
  assign cell_data2 = cell_mem[cell_addr2];
  assign font_row2  = font_mem[font_addr2];

  always #5 clk = ~clk;

  text_pixel_renderer u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sx        (sx),
    .i_sy        (sy),
    .i_x         (x),
    .i_y         (y),
    .i_rd_en     (rd_en),
    .o_cell_rd   (cell_rd),
    .o_cell_addr (cell_addr),
    .i_cell_data (cell_data),
    .o_font_rd   (font_rd),
    .o_font_addr (font_addr),
    .i_font_row  (font_row),
    .o_rd_dv     (rd_dv),
    .o_data      (data),
    .o_in_window (in_win)
  );

  text_pixel_renderer #(
    .SCALE_X (2),
    .SCALE_Y (2)
  ) u_dut_scaled (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sx        (sx),
    .i_sy        (sy),
    .i_x         (x),
    .i_y         (y),
    .i_rd_en     (rd_en),
    .o_cell_rd   (cell_rd2),
    .o_cell_addr (cell_addr2),
    .i_cell_data (cell_data2),
    .o_font_rd   (font_rd2),
    .o_font_addr (font_addr2),
    .i_font_row  (font_row2),
    .o_rd_dv     (rd_dv2),
    .o_data      (data2),
    .o_in_window (in_win2)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [8:0]  last_cell;
  logic [11:0] last_font;
  bit exp_d [1000];
  bit exp_w [1000];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Reference pixel for the default geometry with the window at (100, 50).
  function automatic bit ref_pix(input int psx, input int psy, output bit win);
    int rx, ry, code;
    logic [7:0] fr;
    rx  = psx - 100;
    ry  = psy - 50;
    win = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 304);
    if (!win) return 1'b0;
    code = int'(cell_mem[(ry / 16) * 16 + rx / 8]);
    fr   = font_mem[code * 16 + ry % 16];
    return fr[7 - rx % 8];
  endfunction

  // One isolated request on the default instance, checked at each pipeline stage.
  task automatic single(input string tag, input int psx, input int psy, input bit exp_in,
                        input int exp_ca, input int exp_fa, input bit exp_px);
    @(negedge clk);
    sx    = 11'(psx);
    sy    = 10'(psy);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_in) last_cell = 9'(exp_ca);
    check({tag, "_cell_rd"}, 32'(cell_rd), 32'(exp_in));
    check({tag, "_cell_addr"}, 32'(cell_addr), 32'(last_cell));
    check({tag, "_dv_s1"}, 32'({rd_dv, data}), 32'(0));
    @(negedge clk);
    if (exp_in) last_font = 12'(exp_fa);
    check({tag, "_font_rd"}, 32'(font_rd), 32'(exp_in));
    check({tag, "_font_addr"}, 32'(font_addr), 32'(last_font));
    check({tag, "_dv_s2"}, 32'({rd_dv, data}), 32'(0));
    @(negedge clk);
    check({tag, "_dv"}, 32'(rd_dv), 32'(1));
    check({tag, "_data"}, 32'(data), 32'(exp_px));
    check({tag, "_in_win"}, 32'(in_win), 32'(exp_in));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) cell_mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
    cell_mem[0]    = 8'h41;
    cell_mem[35]   = 8'h42;
    cell_mem[15]   = 8'h01;
    cell_mem[288]  = 8'h02;
    cell_mem[17]   = 8'h03;
    font_mem[1040] = 8'b1000_0000;
    font_mem[1063] = 8'b0000_0100;
    font_mem[16]   = 8'b0000_0001;
    font_mem[47]   = 8'b1000_0000;
    font_mem[49]   = 8'b1000_0000;

    sx = '0; sy = '0; x = 11'd100; y = 10'd50; rd_en = 1'b0;
    last_cell = '0;
    last_font = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({cell_rd, font_rd, rd_dv, data, in_win}), 32'(0));
    check("rst_addrs", 32'({cell_addr, font_addr}), 32'(0));
    rst_n = 1'b1;

    single("basic", 100, 50, 1'b1, 0, 1040, 1'b1);
    single("cell35", 129, 89, 1'b1, 35, 1063, 1'b1);
    single("cell35_gx4", 128, 89, 1'b1, 35, 1063, 1'b0);
    single("left_out", 99, 50, 1'b0, 0, 0, 1'b0);
    single("right_in", 227, 50, 1'b1, 15, 16, 1'b1);
    single("right_out", 228, 50, 1'b0, 0, 0, 1'b0);
    single("top_out", 100, 49, 1'b0, 0, 0, 1'b0);
    single("bottom_in", 100, 353, 1'b1, 288, 47, 1'b1);
    single("bottom_out", 100, 354, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a continuous request stream.
    @(negedge clk);
    sx    = 11'd100;
    sy    = 10'd50;
    rd_en = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({cell_rd, font_rd}), 32'(0));
    check("mid_rst_dv", 32'({rd_dv, data, in_win}), 32'(0));
    check("mid_rst_font_addr", 32'(font_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_dv0", 32'(rd_dv), 32'(0));
    @(negedge clk);
    check("post_rst_dv1", 32'(rd_dv), 32'(0));
    @(negedge clk);
    check("post_rst_dv2", 32'(rd_dv), 32'(1));
    check("post_rst_data", 32'(data), 32'(1));
    rd_en = 1'b0;
    repeat (4) @(negedge clk);
    last_cell = 9'd0;
    last_font = 12'd1040;

    // 2x scaled instance: rel (17, 35) -> col 1, gx 0, row 1, gy 1.
    @(negedge clk);
    sx    = 11'd117;
    sy    = 10'd85;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("scale_cell_rd", 32'(cell_rd2), 32'(1));
    check("scale_cell_addr", 32'(cell_addr2), 32'(17));
    @(negedge clk);
    check("scale_font_rd", 32'(font_rd2), 32'(1));
    check("scale_font_addr", 32'(font_addr2), 32'(49));
    @(negedge clk);
    check("scale_dv", 32'(rd_dv2), 32'(1));
    check("scale_data", 32'(data2), 32'(1));
    check("scale_in_win", 32'(in_win2), 32'(1));

    // Scaled window is 256 wide; rel_x = 256 is just outside.
    @(negedge clk);
    sx    = 11'd356;
    sy    = 10'd85;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("scale_out_cell_rd", 32'(cell_rd2), 32'(0));
    @(negedge clk);
    check("scale_out_font_rd", 32'(font_rd2), 32'(0));
    @(negedge clk);
    check("scale_out_dv", 32'(rd_dv2), 32'(1));
    check("scale_out_data", 32'({data2, in_win2}), 32'(0));

    // Back-to-back scanline through the default instance.
    for (int c = 0; c < 1003; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check("tp_dv", 32'(rd_dv), 32'(1));
        check("tp_data", 32'(data), 32'(exp_d[c - 3]));
        check("tp_in_win", 32'(in_win), 32'(exp_w[c - 3]));
      end
      if (c < 1000) begin
        sx       = 11'(c);
        sy       = 10'd133;
        rd_en    = 1'b1;
        exp_d[c] = ref_pix(c, 133, exp_w[c]);
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    check("tp_idle_dv", 32'({rd_dv, data}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_pixel_renderer.md
Name: text_pixel_renderer

Overview:
- Read-side counterpart of the character-cell writer.
- For each scan position it does three things:
  - fetches the character code stored in the character-cell buffer;
  - looks up the matching glyph row in the font ROM;
  - returns one monochrome pixel bit.
- Sits between the video timing generator (sx/sy) and the pixel mixer. Uses external synchronous RAM/ROM ports with 1-cycle read latency.
- Fully pipelined: accepts one request per clock.

Parameters:
- HORIZONTAL_WIDTH, 1650, total horizontal count; sets sx/x width = $clog2(HORIZONTAL_WIDTH).
- VERTICAL_WIDTH, 750, total vertical count; sets sy/y width = $clog2(VERTICAL_WIDTH).
- COLUMNS, 16, character cells per text row.
- ROWS, 19, text rows.
- CHAR_PIXELS_X, 8, glyph width in pixels.
- CHAR_PIXELS_Y, 16, glyph height in pixels.
- SCALE_X, 1, horizontal pixel replication factor (>=1).
- SCALE_Y, 1, vertical pixel replication factor (>=1).

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_sx, input, $clog2(HORIZONTAL_WIDTH), current scan x.
- i_sy, input, $clog2(VERTICAL_WIDTH), current scan y.
- i_x, input, $clog2(HORIZONTAL_WIDTH), text window origin x.
- i_y, input, $clog2(VERTICAL_WIDTH), text window origin y.
- i_rd_en, input, 1, pixel request valid this cycle.
- o_cell_rd, output, 1, cell buffer read strobe.
- o_cell_addr, output, $clog2(COLUMNS*ROWS), cell index = row*COLUMNS+col.
- i_cell_data, input, 8, character code, valid 1 cycle after o_cell_rd.
- o_font_rd, output, 1, font ROM read strobe.
- o_font_addr, output, $clog2(256*CHAR_PIXELS_Y), address = code*CHAR_PIXELS_Y+glyph_y.
- i_font_row, input, CHAR_PIXELS_X, glyph row bits, valid 1 cycle after o_font_rd; MSB = leftmost pixel.
- o_rd_dv, output, 1, pixel result valid.
- o_data, output, 1, pixel value (1 = foreground).
- o_in_window, output, 1, qualifies o_data; pixel lay inside the text window.

Behaviour:
- Reset: i_rst_n low asynchronously clears all pipeline valid/in-window flags and every output to 0. In-flight requests are discarded, not completed. The first request after deassertion is accepted on the first rising edge with i_rst_n high.
- Window test (stage 0, combinational on inputs):
  - W = COLUMNS*CHAR_PIXELS_X*SCALE_X, H = ROWS*CHAR_PIXELS_Y*SCALE_Y.
  - rel_x = i_sx - i_x, computed one bit wider so underflow is detectable; likewise rel_y.
  - in_window = (i_sx >= i_x) && (rel_x < W) && (i_sy >= i_y) && (rel_y < H).
  - Right and bottom edges are exclusive.
- Coordinates:
  - col = rel_x / (CHAR_PIXELS_X*SCALE_X); glyph_x = (rel_x / SCALE_X) % CHAR_PIXELS_X.
  - row = rel_y / (CHAR_PIXELS_Y*SCALE_Y); glyph_y = (rel_y / SCALE_Y) % CHAR_PIXELS_Y.
  - All divisors are constants.
- Pipeline, cycle N = i_rd_en sampled high:
  - N (registered at edge ending N):
    - o_cell_rd = i_rd_en && in_window; o_cell_addr = row*COLUMNS+col.
    - Carry valid, in_window, glyph_x, glyph_y forward.
  - N+1: i_cell_data valid.
    - o_font_rd = carried valid && in_window; o_font_addr = {i_cell_data, glyph_y} arithmetic.
  - N+2: i_font_row valid.
  - N+3: o_rd_dv = 1 for exactly one cycle.
    - o_data = i_font_row[CHAR_PIXELS_X-1-glyph_x] when in_window, else 0.
    - o_in_window = carried in_window.
- Latency is fixed at 3 cycles from request to o_rd_dv. There is no backpressure.
- Throughput: back-to-back i_rd_en produces back-to-back o_rd_dv, in order.
- Out-of-window requests:
  - still produce o_rd_dv with o_data = 0 and o_in_window = 0;
  - never assert o_cell_rd or o_font_rd.
- Idle outputs:
  - o_cell_addr/o_font_addr hold their last values when the strobe is low;
  - o_data is 0 whenever o_rd_dv = 0.
- i_x/i_y may change at any cycle. They are sampled only with the request in stage 0; in-flight pixels are unaffected.

Test Plan:
- Reset mid-stream: i_rd_en high continuously, pull i_rst_n low at cycle 5 for 2 cycles -> all outputs 0 immediately (asynchronously). First o_rd_dv occurs 3 cycles after the first post-reset request.
- Basic lookup: i_x=100, i_y=50, i_sx=100, i_sy=50, cell 0 = 8'h41, font row 65*16+0 = 8'b1000_0000 -> o_cell_addr=0, then o_font_addr=1040, then o_rd_dv=1, o_data=1 at N+3.
- Cell addressing: i_sx=100+8*3+5, i_sy=50+16*2+7 -> o_cell_addr=35, glyph_y=7, o_data = bit 2 of the returned row.
- Window edges:
  - i_sx=i_x-1 -> o_in_window=0, o_data=0, no strobes.
  - i_sx=i_x+127 (last column) -> in window.
  - i_sx=i_x+128 -> out.
  - Same checks on y at 303/304.
- Scaling: SCALE_X=2, SCALE_Y=2, rel_x=17, rel_y=35 -> col=1, glyph_x=0, row=1, glyph_y=1.
- Throughput: 1000 consecutive requests across a scanline against a model RAM/ROM -> 1000 consecutive o_rd_dv pulses in order, each o_data matching the reference model.
